// File: rtl/mem_sequencer_if.sv
// rtl/mem_sequencer_if.sv - request/response and memory-port signal bundle for mem_sequencer
interface mem_sequencer_if #(
    parameter int MEM_SIZE   = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [MEM_SIZE-1:0]   req_address;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  busy;
    logic                  mem_write;
    logic [MEM_SIZE-1:0]   mem_address;
    logic [DATA_WIDTH-1:0] mem_in;
    logic [DATA_WIDTH-1:0] mem_out;

    // master = requester plus the memory itself; slave = the sequencer
    modport master (
        output req_valid, req_write, req_address, req_data, rsp_ready, mem_out,
        input  req_ready, rsp_valid, rsp_data, busy, mem_write, mem_address, mem_in
    );

    modport slave (
        input  req_valid, req_write, req_address, req_data, rsp_ready, mem_out,
        output req_ready, rsp_valid, rsp_data, busy, mem_write, mem_address, mem_in
    );
endinterface

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - valid/ready front-end for a 1-cycle-latency single-port memory
// Optional memory clear sweep enabled by defining MEM_SEQ_CLEAR_EN.
module mem_sequencer #(
    parameter int MEM_SIZE   = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RSP_DEPTH  = 4
) (
    input  logic clk,
    input  logic reset_n,
`ifdef MEM_SEQ_CLEAR_EN
    input  logic clear_start,
    output logic clear_done,
`endif
    mem_sequencer_if.slave bus
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] fifo [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  pending;
    logic [CW:0]           occupancy;
    logic [MEM_SIZE-1:0]   addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  in_run;
    logic                  in_clear;
    logic [MEM_SIZE-1:0]   sweep;
    logic                  ready;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  mem_write_c;
    logic [MEM_SIZE-1:0]   mem_address_c;
    logic [DATA_WIDTH-1:0] mem_in_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef MEM_SEQ_CLEAR_EN
    typedef enum logic [1:0] {RUN, CLEAR_WAIT, CLEAR, DONE} state_t;
    state_t state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            sweep      <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                RUN:        if (clear_start) state <= CLEAR_WAIT;
                // in-flight responses must drain before the sweep starts
                CLEAR_WAIT: if (!pending && count == '0) begin
                    state <= CLEAR;
                    sweep <= '0;
                end
                CLEAR: begin
                    sweep <= sweep + 1'b1;
                    if (sweep == '1) begin
                        state      <= DONE;
                        clear_done <= 1'b1;
                    end
                end
                DONE:       state <= RUN;
                default:    state <= RUN;
            endcase
        end
    end

    assign in_run   = (state == RUN);
    assign in_clear = (state == CLEAR);
`else
    assign in_run   = 1'b1;
    assign in_clear = 1'b0;
    assign sweep    = '0;
`endif

    assign occupancy = {1'b0, count} + {{CW{1'b0}}, pending};
    assign ready     = in_run && (occupancy < DEPTH_W);
    assign accept    = bus.req_valid && ready;
    assign push      = pending;
    assign pop       = (count != '0) && bus.rsp_ready;

    // mem_write is gated by reset because the memory has no reset of its own
    always_comb begin
        mem_write_c   = 1'b0;
        mem_address_c = addr_q;
        mem_in_c      = din_q;
        if (!reset_n) begin
            mem_write_c = 1'b0;
        end else if (in_clear) begin
            mem_write_c   = 1'b1;
            mem_address_c = sweep;
            mem_in_c      = '0;
        end else if (accept) begin
            mem_write_c   = bus.req_write;
            mem_address_c = bus.req_address;
            mem_in_c      = bus.req_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo[i] <= '0;
        end else begin
            pending <= accept;
            addr_q  <= mem_address_c;
            din_q   <= mem_in_c;
            if (push) begin
                fifo[wr_ptr] <= bus.mem_out;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && count == CW'(RSP_DEPTH)));

    assign bus.req_ready   = ready;
    assign bus.rsp_valid   = (count != '0);
    assign bus.rsp_data    = fifo[rd_ptr];
    assign bus.busy        = pending || (count != '0) || !in_run;
    assign bus.mem_write   = mem_write_c;
    assign bus.mem_address = mem_address_c;
    assign bus.mem_in      = mem_in_c;
endmodule

// File: tb/tb_mem_sequencer.sv
// tb/tb_mem_sequencer.sv - directed self-checking bench for mem_sequencer (optionally with MEM_SEQ_CLEAR_EN)
module tb_mem_sequencer;
`ifdef MEM_SEQ_CLEAR_EN
    localparam int MS = 4;
`else
    localparam int MS = 8;
`endif
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear_start = 1'b0;
    logic clear_done;
    int   vec = 0;
    int   err = 0;
    int   nclr = 0;
    int   ndone = 0;
    int   n;
    logic ok;
    logic [DW-1:0] mem [2**MS];
    logic [DW-1:0] rq [$];
    logic [MS-1:0] a3 [6];
    logic [DW-1:0] e3 [6];

    mem_sequencer_if #(.MEM_SIZE(MS), .DATA_WIDTH(DW)) bus ();

    mem_sequencer #(.MEM_SIZE(MS), .DATA_WIDTH(DW), .RSP_DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef MEM_SEQ_CLEAR_EN
        .clear_start(clear_start),
        .clear_done (clear_done),
`endif
        .bus        (bus)
    );

`ifndef MEM_SEQ_CLEAR_EN
    assign clear_done = 1'b0;
`endif

    always #5 clk = ~clk;

    // write-first single-port memory with registered output
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_address] <= bus.mem_in;
        bus.mem_out <= bus.mem_write ? bus.mem_in : mem[bus.mem_address];
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.rsp_valid && bus.rsp_ready) rq.push_back(bus.rsp_data);
            if (bus.mem_write && bus.mem_in == '0) nclr++;
            if (clear_done) ndone++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && bus.busy; i++) tick();
        chk(tag, 32'(bus.busy), 0);
    endtask

    task automatic drive(input logic wr, input logic [MS-1:0] a, input logic [DW-1:0] d);
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_address = a;
        bus.req_data    = d;
    endtask

    initial begin
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_address = '0;
        bus.req_data = 8'h00;
        bus.rsp_ready = 1'b0;
        a3 = '{0, 1, 2, 5, 0, 1};
        e3 = '{8'h11, 8'h22, 8'h33, 8'h3C, 8'h11, 8'h22};

        // reset state
        tick(); tick(); tick();
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_mem_write", 32'(bus.mem_write), 0);
        bus.req_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.req_ready), 1);

        // 1: write then read address 5
        drive(1'b1, 5, 8'h3C);
        bus.rsp_ready = 1'b1;
        #1;
        chk("t1_mem_write", 32'(bus.mem_write), 1);
        chk("t1_mem_addr", 32'(bus.mem_address), 5);
        chk("t1_mem_in", 32'(bus.mem_in), 32'h3C);
        tick();
        bus.req_valid = 1'b0;
        chk("t1_lat1_valid", 32'(bus.rsp_valid), 0);
        chk("t1_lat1_busy", 32'(bus.busy), 1);
        tick();
        chk("t1_lat2_valid", 32'(bus.rsp_valid), 1);
        chk("t1_wr_echo", 32'(bus.rsp_data), 32'h3C);
        tick();
        chk("t1_popped", 32'(bus.rsp_valid), 0);
        chk("t1_addr_hold", 32'(bus.mem_address), 5);
        chk("t1_idle_write", 32'(bus.mem_write), 0);
        drive(1'b0, 5, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("t1_rd_valid", 32'(bus.rsp_valid), 1);
        chk("t1_rd_data", 32'(bus.rsp_data), 32'h3C);
        tick();

        // 2: back-to-back reads at full rate
        drive(1'b0, 0, 8'h00);
        tick();
        chk("t2_ready_a", 32'(bus.req_ready), 1);
        drive(1'b0, 1, 8'h00);
        tick();
        chk("t2_ready_b", 32'(bus.req_ready), 1);
        chk("t2_rsp0", 32'(bus.rsp_data), 32'h11);
        drive(1'b0, 2, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        chk("t2_rsp1", 32'(bus.rsp_data), 32'h22);
        chk("t2_rsp1_valid", 32'(bus.rsp_valid), 1);
        tick();
        chk("t2_rsp2", 32'(bus.rsp_data), 32'h33);
        chk("t2_rsp2_valid", 32'(bus.rsp_valid), 1);
        tick();
        chk("t2_drained", 32'(bus.rsp_valid), 0);

        // 3: backpressure fills the buffer, then drains in order
        rq.delete();
        n = 0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, a3[n], 8'h00);
            ok = bus.req_ready;
            tick();
            if (ok) n++;
        end
        chk("t3_accepted", 32'(n), 4);
        chk("t3_ready_low", 32'(bus.req_ready), 0);
        chk("t3_head", 32'(bus.rsp_data), 32'h11);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 30 && n < 6; i++) begin
            drive(1'b0, a3[n], 8'h00);
            ok = bus.req_ready;
            tick();
            if (ok) n++;
        end
        bus.req_valid = 1'b0;
        wait_idle("t3_idle");
        chk("t3_total", 32'(n), 6);
        chk("t3_rsp_count", 32'(rq.size()), 6);
        for (int k = 0; k < 6 && k < rq.size(); k++) chk($sformatf("t3_rsp%0d", k), 32'(rq[k]), 32'(e3[k]));

        // 4: write then immediate read of the same address
        rq.delete();
        drive(1'b1, 7, 8'hAA);
        tick();
        drive(1'b0, 7, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        wait_idle("t4_idle");
        chk("t4_rsp_count", 32'(rq.size()), 2);
        if (rq.size() == 2) begin
            chk("t4_echo", 32'(rq[0]), 32'hAA);
            chk("t4_read", 32'(rq[1]), 32'hAA);
        end

`ifdef MEM_SEQ_CLEAR_EN
        // 5: clear with two responses still buffered
        rq.delete();
        bus.rsp_ready = 1'b0;
        drive(1'b0, 0, 8'h00);
        tick();
        drive(1'b0, 1, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        tick();
        nclr = 0;
        ndone = 0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("t5_ready_low", 32'(bus.req_ready), 0);
        tick();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 60 && ndone == 0; i++) tick();
        wait_idle("t5_idle");
        chk("t5_rsp_count", 32'(rq.size()), 2);
        if (rq.size() == 2) begin
            chk("t5_rsp0", 32'(rq[0]), 32'h11);
            chk("t5_rsp1", 32'(rq[1]), 32'h22);
        end
        chk("t5_clear_writes", 32'(nclr), 16);
        chk("t5_done_pulses", 32'(ndone), 1);
        chk("t5_ready_after", 32'(bus.req_ready), 1);
        rq.delete();
        drive(1'b0, 9, 8'h00);
        tick();
        drive(1'b0, 0, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        wait_idle("t5_rd_idle");
        chk("t5_rd_count", 32'(rq.size()), 2);
        if (rq.size() == 2) begin
            chk("t5_rd9", 32'(rq[0]), 0);
            chk("t5_rd0", 32'(rq[1]), 0);
        end

        // 6a: reset mid-clear
        ndone = 0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t6a_busy_clear", 32'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        chk("t6a_busy", 32'(bus.busy), 0);
        chk("t6a_mem_write", 32'(bus.mem_write), 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6a_ready", 32'(bus.req_ready), 1);
        for (int i = 0; i < 25; i++) tick();
        chk("t6a_no_done", 32'(ndone), 0);
`endif

        // 6: reset with responses buffered
        bus.rsp_ready = 1'b0;
        drive(1'b0, 0, 8'h00);
        tick(); tick(); tick();
        bus.req_valid = 1'b0;
        tick(); tick();
        chk("t6_pre_valid", 32'(bus.rsp_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_rsp_data", 32'(bus.rsp_data), 0);
        tick();
        reset_n = 1'b1;
        rq.delete();
        bus.rsp_ready = 1'b1;
        tick();
        chk("t6_ready", 32'(bus.req_ready), 1);
        for (int i = 0; i < 6; i++) tick();
        chk("t6_no_stale", 32'(rq.size()), 0);
        chk("t6_valid_low", 32'(bus.rsp_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
